// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the core memory bus arbiter: FSM state and bus owner encodings.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    ERR_RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned TO_CNT_W    = 8;
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the memory bus.
interface mem_bus_arbiter_if;

  logic        if_req_valid_i;
  logic        if_req_ready_o;
  logic [31:0] if_addr_i;
  logic        if_rsp_valid_o;
  logic [31:0] if_rsp_data_o;
  logic        if_rsp_err_o;

  logic        ls_req_valid_i;
  logic        ls_req_ready_o;
  logic [31:0] ls_addr_i;
  logic        ls_write_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_strobe_i;
  logic        ls_illegal_i;
  logic        ls_rsp_valid_o;
  logic [31:0] ls_rsp_data_o;
  logic        ls_rsp_err_o;

  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_write_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_strobe_o;
  logic        bus_rsp_valid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_rsp_err_i;

  logic        owner_o;

  // Arbiter view
  modport master (
    input  if_req_valid_i, if_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    input  ls_req_valid_i, ls_addr_i, ls_write_i, ls_wdata_i, ls_strobe_i, ls_illegal_i,
    output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    output bus_req_valid_o, bus_addr_o, bus_write_o, bus_wdata_o, bus_strobe_o,
    input  bus_req_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_rsp_err_i,
    output owner_o
  );

  // Environment view (requesters plus memory)
  modport slave (
    output if_req_valid_i, if_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    output ls_req_valid_i, ls_addr_i, ls_write_i, ls_wdata_i, ls_strobe_i, ls_illegal_i,
    input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    input  bus_req_valid_o, bus_addr_o, bus_write_o, bus_wdata_o, bus_strobe_o,
    output bus_req_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_rsp_err_i,
    input  owner_o
  );

endinterface

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// Response timeout counter: counts enabled cycles, flags the LIMIT-th one; LIMIT=0 disables.
module arb_timeout_ctr
  import core_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : TO_CNT_W'(LIMIT - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose edge completes LIMIT enabled cycles.
  assign expired_o = (LIMIT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing the core memory bus between fetch and load/store,
// with fixed data priority, a fetch starvation guard, and error/timeout responses.
module mem_bus_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_bus_arbiter_if.master  bus
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic [31:0]             addr_q, addr_d;
  logic                    write_q, write_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              strobe_q, strobe_d;

  logic                    if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]             if_rsp_data_q, if_rsp_data_d;
  logic                    if_rsp_err_q, if_rsp_err_d;
  logic                    ls_rsp_valid_q, ls_rsp_valid_d;
  logic [31:0]             ls_rsp_data_q, ls_rsp_data_d;
  logic                    ls_rsp_err_q, ls_rsp_err_d;

  logic                    fetch_win, ls_win;
  logic                    rsp_fire;
  logic [31:0]             rsp_data;
  logic                    rsp_err;
  logic                    to_expired;

  arb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != WAIT_RSP),
    .en_i      (state_q == WAIT_RSP),
    .expired_o (to_expired)
  );

  assign fetch_win = bus.if_req_valid_i && (!bus.ls_req_valid_i || (starve_q == STARVE_MAX));
  assign ls_win    = bus.ls_req_valid_i && !fetch_win;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    addr_d         = addr_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    strobe_d       = strobe_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    ls_rsp_valid_d = 1'b0;
    ls_rsp_data_d  = ls_rsp_data_q;
    ls_rsp_err_d   = ls_rsp_err_q;
    rsp_fire       = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;

    if (!bus.if_req_valid_i) begin
      starve_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (fetch_win) begin
          owner_d  = OWN_IF;
          starve_d = '0;
          addr_d   = bus.if_addr_i;
          write_d  = 1'b0;
          wdata_d  = '0;
          strobe_d = '0;
          state_d  = ISSUE;
        end else if (ls_win) begin
          owner_d = OWN_LS;
          if (bus.if_req_valid_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
          // Illegal requests answer straight from here so the error lands one cycle after grant.
          if (bus.ls_illegal_i) begin
            ls_rsp_valid_d = 1'b1;
            ls_rsp_data_d  = '0;
            ls_rsp_err_d   = 1'b1;
            state_d        = ERR_RSP;
          end else begin
            addr_d   = bus.ls_addr_i;
            write_d  = bus.ls_write_i;
            wdata_d  = bus.ls_wdata_i;
            strobe_d = bus.ls_strobe_i;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.bus_req_ready_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.bus_rsp_valid_i) begin
          rsp_fire = 1'b1;
          rsp_data = bus.bus_rdata_i;
          rsp_err  = bus.bus_rsp_err_i;
          state_d  = IDLE;
        end else if (to_expired) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      ERR_RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rsp_fire) begin
      if (owner_q == OWN_LS) begin
        ls_rsp_valid_d = 1'b1;
        ls_rsp_data_d  = rsp_data;
        ls_rsp_err_d   = rsp_err;
      end else begin
        if_rsp_valid_d = 1'b1;
        if_rsp_data_d  = rsp_data;
        if_rsp_err_d   = rsp_err;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      starve_q       <= '0;
      addr_q         <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      strobe_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      starve_q       <= starve_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      strobe_q       <= strobe_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

  // Grant readies are combinational but forced low while reset is held.
  assign bus.if_req_ready_o  = !rst_i && (state_q == IDLE) && fetch_win;
  assign bus.ls_req_ready_o  = !rst_i && (state_q == IDLE) && ls_win;

  assign bus.bus_req_valid_o = (state_q == ISSUE);
  assign bus.bus_addr_o      = addr_q;
  assign bus.bus_write_o     = write_q;
  assign bus.bus_wdata_o     = wdata_q;
  assign bus.bus_strobe_o    = strobe_q;

  assign bus.if_rsp_valid_o  = if_rsp_valid_q;
  assign bus.if_rsp_data_o   = if_rsp_data_q;
  assign bus.if_rsp_err_o    = if_rsp_err_q;
  assign bus.ls_rsp_valid_o  = ls_rsp_valid_q;
  assign bus.ls_rsp_data_o   = ls_rsp_data_q;
  assign bus.ls_rsp_err_o    = ls_rsp_err_q;

  assign bus.owner_o         = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_bus_arbiter_if mbi ();

  mem_bus_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    mbi.if_req_valid_i  = 1'b0;
    mbi.if_addr_i       = '0;
    mbi.ls_req_valid_i  = 1'b0;
    mbi.ls_addr_i       = '0;
    mbi.ls_write_i      = 1'b0;
    mbi.ls_wdata_i      = '0;
    mbi.ls_strobe_i     = '0;
    mbi.ls_illegal_i    = 1'b0;
    mbi.bus_req_ready_i = 1'b0;
    mbi.bus_rsp_valid_i = 1'b0;
    mbi.bus_rdata_i     = '0;
    mbi.bus_rsp_err_i   = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_bus_valid", 32'(mbi.bus_req_valid_o), 32'd0);
    chk("rst_if_rsp",    32'(mbi.if_rsp_valid_o),  32'd0);
    chk("rst_ls_rsp",    32'(mbi.ls_rsp_valid_o),  32'd0);
    chk("rst_owner",     32'(mbi.owner_o),         32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch, response three cycles into WAIT_RSP
    mbi.if_req_valid_i  = 1'b1;
    mbi.if_addr_i       = 32'h0000_0100;
    mbi.bus_req_ready_i = 1'b1;
    #1;
    chk("f_if_ready", 32'(mbi.if_req_ready_o), 32'd1);
    chk("f_ls_ready", 32'(mbi.ls_req_ready_o), 32'd0);
    tick();
    mbi.if_req_valid_i = 1'b0;
    chk("f_bus_valid", 32'(mbi.bus_req_valid_o), 32'd1);
    chk("f_bus_addr",  mbi.bus_addr_o,           32'h0000_0100);
    chk("f_bus_write", 32'(mbi.bus_write_o),     32'd0);
    chk("f_owner",     32'(mbi.owner_o),         32'd0);
    tick();
    chk("f_bus_valid_drop", 32'(mbi.bus_req_valid_o), 32'd0);
    tick();
    tick();
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'hDEAD_BEEF;
    tick();
    mbi.bus_rsp_valid_i = 1'b0;
    chk("f_rsp_valid", 32'(mbi.if_rsp_valid_o), 32'd1);
    chk("f_rsp_data",  mbi.if_rsp_data_o,       32'hDEAD_BEEF);
    chk("f_rsp_err",   32'(mbi.if_rsp_err_o),   32'd0);
    chk("f_ls_silent", 32'(mbi.ls_rsp_valid_o), 32'd0);
    tick();
    chk("f_rsp_pulse", 32'(mbi.if_rsp_valid_o), 32'd0);
    chk("f_rsp_hold",  mbi.if_rsp_data_o,       32'hDEAD_BEEF);

    // Both ports hammering: four data grants, then fetch, then data again
    mbi.if_req_valid_i  = 1'b1;
    mbi.if_addr_i       = 32'h0000_0400;
    mbi.ls_req_valid_i  = 1'b1;
    mbi.ls_addr_i       = 32'h0000_0500;
    mbi.bus_req_ready_i = 1'b1;
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'hA5A5_0001;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("arb_if_ready_%0d", g), 32'(mbi.if_req_ready_o), (g == 4) ? 32'd1 : 32'd0);
      chk($sformatf("arb_ls_ready_%0d", g), 32'(mbi.ls_req_ready_o), (g == 4) ? 32'd0 : 32'd1);
      tick();
      tick();
      tick();
    end
    mbi.if_req_valid_i  = 1'b0;
    mbi.ls_req_valid_i  = 1'b0;
    mbi.bus_rsp_valid_i = 1'b0;
    chk("arb_last_ls_rsp", 32'(mbi.ls_rsp_valid_o), 32'd1);
    chk("arb_last_if_rsp", 32'(mbi.if_rsp_valid_o), 32'd0);
    chk("arb_last_data",   mbi.ls_rsp_data_o,       32'hA5A5_0001);
    tick();

    // Illegal store: error one cycle after grant, bus untouched
    mbi.ls_req_valid_i = 1'b1;
    mbi.ls_addr_i      = 32'h0000_0003;
    mbi.ls_write_i     = 1'b1;
    mbi.ls_wdata_i     = 32'h7777_7777;
    mbi.ls_strobe_i    = 4'b1000;
    mbi.ls_illegal_i   = 1'b1;
    #1;
    chk("ill_ready", 32'(mbi.ls_req_ready_o), 32'd1);
    tick();
    mbi.ls_req_valid_i = 1'b0;
    mbi.ls_illegal_i   = 1'b0;
    chk("ill_rsp_valid", 32'(mbi.ls_rsp_valid_o),  32'd1);
    chk("ill_rsp_err",   32'(mbi.ls_rsp_err_o),    32'd1);
    chk("ill_rsp_data",  mbi.ls_rsp_data_o,        32'd0);
    chk("ill_bus_idle",  32'(mbi.bus_req_valid_o), 32'd0);
    chk("ill_if_silent", 32'(mbi.if_rsp_valid_o),  32'd0);
    tick();
    chk("ill_rsp_pulse", 32'(mbi.ls_rsp_valid_o),  32'd0);
    chk("ill_bus_idle2", 32'(mbi.bus_req_valid_o), 32'd0);

    // Timeout: bus never answers, error 8 cycles after acceptance
    mbi.ls_req_valid_i  = 1'b1;
    mbi.ls_addr_i       = 32'h0000_0040;
    mbi.ls_write_i      = 1'b0;
    mbi.ls_strobe_i     = 4'b0000;
    mbi.bus_req_ready_i = 1'b1;
    tick();
    mbi.ls_req_valid_i = 1'b0;
    chk("to_bus_valid", 32'(mbi.bus_req_valid_o), 32'd1);
    tick();
    for (int c = 1; c < 8; c++) begin
      tick();
    end
    chk("to_not_yet", 32'(mbi.ls_rsp_valid_o), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(mbi.ls_rsp_valid_o), 32'd1);
    chk("to_rsp_err",   32'(mbi.ls_rsp_err_o),   32'd1);
    chk("to_rsp_data",  mbi.ls_rsp_data_o,       32'd0);
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'h5555_5555;
    tick();
    mbi.bus_rsp_valid_i = 1'b0;
    chk("late_ls_ignored", 32'(mbi.ls_rsp_valid_o), 32'd0);
    chk("late_if_ignored", 32'(mbi.if_rsp_valid_o), 32'd0);
    mbi.if_req_valid_i = 1'b1;
    mbi.if_addr_i      = 32'h0000_0200;
    #1;
    chk("post_to_ready", 32'(mbi.if_req_ready_o), 32'd1);
    tick();
    mbi.if_req_valid_i = 1'b0;
    chk("post_to_addr", mbi.bus_addr_o, 32'h0000_0200);
    tick();
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'h1111_1111;
    tick();
    mbi.bus_rsp_valid_i = 1'b0;
    chk("post_to_rsp",  32'(mbi.if_rsp_valid_o), 32'd1);
    chk("post_to_data", mbi.if_rsp_data_o,       32'h1111_1111);
    tick();

    // Bus stalls ten cycles: latched store fields hold, no timeout in ISSUE
    mbi.ls_req_valid_i  = 1'b1;
    mbi.ls_addr_i       = 32'h0000_0080;
    mbi.ls_write_i      = 1'b1;
    mbi.ls_wdata_i      = 32'h1234_1234;
    mbi.ls_strobe_i     = 4'b1100;
    mbi.bus_req_ready_i = 1'b0;
    tick();
    mbi.ls_req_valid_i = 1'b0;
    mbi.ls_addr_i      = 32'hFFFF_FFF0;
    mbi.ls_wdata_i     = 32'h0BAD_0BAD;
    mbi.ls_strobe_i    = 4'b0011;
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("stall_valid_%0d", s),  32'(mbi.bus_req_valid_o), 32'd1);
      chk($sformatf("stall_addr_%0d", s),   mbi.bus_addr_o,           32'h0000_0080);
      chk($sformatf("stall_wdata_%0d", s),  mbi.bus_wdata_o,          32'h1234_1234);
      chk($sformatf("stall_strobe_%0d", s), 32'(mbi.bus_strobe_o),    32'hC);
      tick();
    end
    chk("stall_write", 32'(mbi.bus_write_o), 32'd1);
    mbi.bus_req_ready_i = 1'b1;
    tick();
    chk("stall_accepted", 32'(mbi.bus_req_valid_o), 32'd0);
    chk("stall_owner",    32'(mbi.owner_o),         32'd1);
    for (int w = 0; w < 6; w++) begin
      tick();
    end
    chk("stall_no_timeout", 32'(mbi.ls_rsp_valid_o), 32'd0);
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'hCAFE_0000;
    mbi.bus_rsp_err_i   = 1'b0;
    tick();
    mbi.bus_rsp_valid_i = 1'b0;
    chk("stall_rsp_valid", 32'(mbi.ls_rsp_valid_o), 32'd1);
    chk("stall_rsp_err",   32'(mbi.ls_rsp_err_o),   32'd0);
    chk("stall_rsp_data",  mbi.ls_rsp_data_o,       32'hCAFE_0000);
    tick();

    // Reset in WAIT_RSP: outputs clear at once, the later response is dropped
    mbi.ls_req_valid_i = 1'b1;
    mbi.ls_addr_i      = 32'h0000_0300;
    mbi.ls_write_i     = 1'b0;
    mbi.ls_strobe_i    = 4'b0000;
    tick();
    mbi.ls_req_valid_i = 1'b0;
    tick();
    chk("rw_owner_before", 32'(mbi.owner_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rw_bus_valid", 32'(mbi.bus_req_valid_o), 32'd0);
    chk("rw_bus_addr",  mbi.bus_addr_o,           32'd0);
    chk("rw_owner",     32'(mbi.owner_o),         32'd0);
    chk("rw_ls_data",   mbi.ls_rsp_data_o,        32'd0);
    chk("rw_if_data",   mbi.if_rsp_data_o,        32'd0);
    tick();
    rst = 1'b0;
    mbi.bus_rsp_valid_i = 1'b1;
    mbi.bus_rdata_i     = 32'h9999_9999;
    tick();
    mbi.bus_rsp_valid_i = 1'b0;
    chk("rw_ls_no_rsp", 32'(mbi.ls_rsp_valid_o), 32'd0);
    chk("rw_if_no_rsp", 32'(mbi.if_rsp_valid_o), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
